// File: rtl/game_clock_controller.sv
// Game clock sequencer: MM:SS countdown, period counter, shot clock.
// Ports: clock_in/reset_n, tick_in, start_pause, shot_reset, next_period
//   in; minutes/seconds/shot/period counts and run/end/expire/over flags
//   out. Shot clock logic is present only when SHOT_CLOCK_EN is defined.
module game_clock_controller #(
  parameter int PERIOD_MIN  = 10,
  parameter int NUM_PERIODS = 4,
  parameter int SHOT_SEC    = 24
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       start_pause,
  input  logic       shot_reset,
  input  logic       next_period,
  output logic [3:0] minutes_out,
  output logic [5:0] seconds_out,
  output logic [4:0] shot_out,
  output logic [2:0] period_out,
  output logic       running_out,
  output logic       period_end_out,
  output logic       shot_expired_out,
  output logic       game_over_out
);

`ifdef SHOT_CLOCK_EN
  localparam bit ShotEn = 1'b1;
`else
  localparam bit ShotEn = 1'b0;
`endif

  localparam logic [3:0] MinInit  = 4'(PERIOD_MIN);
  localparam logic [4:0] ShotInit = ShotEn ? 5'(SHOT_SEC) : 5'd0;
  localparam logic [2:0] LastPer  = 3'(NUM_PERIODS);

  typedef enum logic [2:0] {
    IDLE, RUN, PAUSE, PEND, OVER
  } state_t;

  state_t     state_q, state_n;
  logic [3:0] min_q, min_n;
  logic [5:0] sec_q, sec_n;
  logic [4:0] shot_q, shot_n;
  logic [2:0] per_q, per_n;
  logic       pe_q, pe_n;
  logic       se_q, se_n;
  logic       run_q, over_q;
  logic       shot_block, shot_rl;

  // An expired shot clock locks out start until it is reloaded.
  assign shot_block = ShotEn && (shot_q == 5'd0);
  assign shot_rl    = ShotEn && shot_reset;

  always_comb begin
    state_n = state_q;
    min_n   = min_q;
    sec_n   = sec_q;
    shot_n  = shot_q;
    per_n   = per_q;
    pe_n    = 1'b0;
    se_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (shot_rl) shot_n = ShotInit;
        if (start_pause && !shot_block)
          state_n = RUN;
      end
      RUN: begin
        // Reload beats the tick for the shot clock only.
        if (shot_rl) begin
          shot_n = ShotInit;
        end else if (tick_in && ShotEn
                     && shot_q != 5'd0) begin
          shot_n = shot_q - 5'd1;
          se_n   = (shot_q == 5'd1);
        end
        if (tick_in) begin
          if (sec_q != 6'd0) begin
            sec_n = sec_q - 6'd1;
          end else if (min_q != 4'd0) begin
            min_n = min_q - 4'd1;
            sec_n = 6'd59;
          end
        end
        // Period end outranks the shot auto-pause.
        if (tick_in && min_n == 4'd0
            && sec_n == 6'd0) begin
          pe_n    = 1'b1;
          state_n = (per_q < LastPer) ? PEND : OVER;
        end else if (se_n || start_pause) begin
          state_n = PAUSE;
        end
      end
      PAUSE: begin
        if (shot_rl) shot_n = ShotInit;
        if (start_pause && !shot_block)
          state_n = RUN;
      end
      PEND: begin
        if (next_period) begin
          per_n   = per_q + 3'd1;
          min_n   = MinInit;
          sec_n   = 6'd0;
          shot_n  = ShotInit;
          state_n = IDLE;
        end
      end
      OVER: begin
        state_n = OVER;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      min_q   <= MinInit;
      sec_q   <= 6'd0;
      shot_q  <= ShotInit;
      per_q   <= 3'd1;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      min_q   <= min_n;
      sec_q   <= sec_n;
      shot_q  <= shot_n;
      per_q   <= per_n;
      pe_q    <= pe_n;
      se_q    <= se_n;
      run_q   <= (state_n == RUN);
      over_q  <= (state_n == OVER);
    end
  end

  assign minutes_out      = min_q;
  assign seconds_out      = sec_q;
  assign shot_out         = shot_q;
  assign period_out       = per_q;
  assign running_out      = run_q;
  assign period_end_out   = pe_q;
  assign shot_expired_out = se_q;
  assign game_over_out    = over_q;

endmodule
